// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the pipeline hazard controller.
//   opcode_out_t   - decoded opcode class delivered by the ID stage decoder
//   hazard_state_e - hazard controller FSM states
//   is_branch()    - true for any conditional branch or jump opcode
package hazard_pkg;

  localparam int unsigned LOAD_LAT_MAX = 7;
  localparam int unsigned MD_LAT_MAX   = 15;
  localparam int unsigned OPCODE_W     = 5;

  // Decoded opcode set shared with the ID-stage decoder.
  typedef enum logic [OPCODE_W-1:0] {
    OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA,
    OP_SLT, OP_SLTU, OP_ADDI, OP_LUI, OP_AUIPC, OP_LW, OP_SW,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU, OP_JAL, OP_JALR,
    OP_MUL, OP_DIV
  } opcode_out_t;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_LD_STALL   = 2'd1,
    ST_MD_BUSY    = 2'd2,
    ST_MD_RELEASE = 2'd3
  } hazard_state_e;

  // Branch/jump class: everything that can redirect the PC.
  function automatic logic is_branch(input opcode_out_t op);
    return op inside {OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
                      OP_JAL, OP_JALR};
  endfunction

endpackage

// File: rtl/hazard_stall_timer.sv
// hazard_stall_timer: loadable down-counter that times multi-cycle stalls.
//   clk_i, rst_ni  - clock, synchronous active-low reset
//   load_i         - load load_val_i (takes precedence over dec_i)
//   load_val_i     - value to load
//   dec_i          - decrement by one, holding at zero
//   zero_o         - counter is zero
//   last_o         - counter is one (final cycle of a timed window)
module hazard_stall_timer #(
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o,
  output logic             last_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: load wins, decrement never wraps below zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);
  assign last_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stateful hazard unit beside the ID stage of the 5-stage pipe.
// Detects load-use hazards, freezes the front end for multi-cycle mul/div in
// EX, and handles branches either by an ID-stage bubble (BR_MODE=0) or by a
// predict-not-taken flush on an EX-resolved taken branch (BR_MODE=1).
//   clk_i, rst_ni                  - clock, synchronous active-low reset
//   id_opcode_i                    - decoded opcode of the ID instruction
//   id_rs1/rs2_idx_i, _used_i      - ID source registers and read flags
//   ex_rd_idx_i, ex_mem_read_en_i  - EX destination and load flag
//   ex_md_start_i                  - EX instruction is a mul/div
//   ex_branch_taken_i              - EX branch resolved taken (BR_MODE=1)
//   fe/ifid/idex enables, ifid/idex/exmem clears - pipeline register controls
//   hazard_busy_o                  - controller is inside a timed window
//   stall_cnt_o                    - saturating count of fetch-stall cycles
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_IDX_W = 5,
  parameter int unsigned LOAD_LAT  = 1,
  parameter int unsigned MD_LAT    = 4,
  parameter int unsigned BR_MODE   = 0,
  parameter int unsigned PERF_W    = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  opcode_out_t          id_opcode_i,
  input  logic [REG_IDX_W-1:0] id_rs1_idx_i,
  input  logic [REG_IDX_W-1:0] id_rs2_idx_i,
  input  logic                 id_rs1_used_i,
  input  logic                 id_rs2_used_i,
  input  logic [REG_IDX_W-1:0] ex_rd_idx_i,
  input  logic                 ex_mem_read_en_i,
  input  logic                 ex_md_start_i,
  input  logic                 ex_branch_taken_i,
  output logic                 fe_enable_o,
  output logic                 ifid_enable_o,
  output logic                 ifid_clear_o,
  output logic                 idex_enable_o,
  output logic                 idex_clear_o,
  output logic                 exmem_clear_o,
  output logic                 hazard_busy_o,
  output logic [PERF_W-1:0]    stall_cnt_o
);

  localparam int unsigned LAT_MAX = (LOAD_LAT > MD_LAT) ? LOAD_LAT : MD_LAT;
  localparam int unsigned CNT_W   = $clog2(LAT_MAX + 1);
  localparam logic [PERF_W-1:0] STALL_MAX = '1;

  // Elaboration-time parameter range checks.
  if ((LOAD_LAT < 1) || (LOAD_LAT > LOAD_LAT_MAX)) begin : g_chk_load_lat
    $fatal(1, "hazard_ctrl: LOAD_LAT must be 1..7");
  end
  if ((MD_LAT < 2) || (MD_LAT > MD_LAT_MAX)) begin : g_chk_md_lat
    $fatal(1, "hazard_ctrl: MD_LAT must be 2..15");
  end
  if (BR_MODE > 1) begin : g_chk_br_mode
    $fatal(1, "hazard_ctrl: BR_MODE must be 0 or 1");
  end
  if ((PERF_W < 1) || (REG_IDX_W < 1)) begin : g_chk_widths
    $fatal(1, "hazard_ctrl: PERF_W and REG_IDX_W must be non-zero");
  end

  hazard_state_e     state_q, state_d;
  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
  logic              tmr_load, tmr_dec, tmr_zero, tmr_last;
  logic [CNT_W-1:0]  tmr_val;
  logic              load_use_c;
  logic              br_flush_c;

  // Load-use: x0 never carries a real dependency, unread sources are ignored.
  assign load_use_c = ex_mem_read_en_i && (ex_rd_idx_i != '0) &&
                      ((id_rs1_used_i && (id_rs1_idx_i == ex_rd_idx_i)) ||
                       (id_rs2_used_i && (id_rs2_idx_i == ex_rd_idx_i)));

  assign br_flush_c = (BR_MODE == 1) && ex_branch_taken_i;

  hazard_stall_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero),
    .last_o     (tmr_last)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and same-cycle pipeline controls; reset forces the defaults.
  always_comb begin
    state_d       = state_q;
    fe_enable_o   = 1'b1;
    ifid_enable_o = 1'b1;
    ifid_clear_o  = 1'b0;
    idex_enable_o = 1'b1;
    idex_clear_o  = 1'b0;
    exmem_clear_o = 1'b0;
    tmr_load      = 1'b0;
    tmr_val       = '0;
    tmr_dec       = 1'b0;

    if (!rst_ni) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (br_flush_c) begin
            // Redirect: fetch keeps running from the branch target.
            ifid_clear_o = 1'b1;
            idex_clear_o = 1'b1;
          end else if (ex_md_start_i) begin
            fe_enable_o   = 1'b0;
            ifid_enable_o = 1'b0;
            idex_enable_o = 1'b0;
            exmem_clear_o = 1'b1;
            if (MD_LAT > 2) begin
              state_d  = ST_MD_BUSY;
              tmr_load = 1'b1;
              tmr_val  = CNT_W'(MD_LAT - 2);
            end else begin
              state_d = ST_MD_RELEASE;
            end
          end else if (load_use_c) begin
            fe_enable_o   = 1'b0;
            ifid_enable_o = 1'b0;
            idex_clear_o  = 1'b1;
            if (LOAD_LAT > 1) begin
              state_d  = ST_LD_STALL;
              tmr_load = 1'b1;
              tmr_val  = CNT_W'(LOAD_LAT - 1);
            end
          end else if ((BR_MODE == 0) && is_branch(id_opcode_i)) begin
            fe_enable_o  = 1'b0;
            ifid_clear_o = 1'b1;
          end
        end
        ST_LD_STALL: begin
          fe_enable_o   = 1'b0;
          ifid_enable_o = 1'b0;
          idex_clear_o  = 1'b1;
          tmr_dec       = 1'b1;
          if (tmr_last || tmr_zero) begin
            state_d = ST_IDLE;
          end
        end
        ST_MD_BUSY: begin
          fe_enable_o   = 1'b0;
          ifid_enable_o = 1'b0;
          idex_enable_o = 1'b0;
          exmem_clear_o = 1'b1;
          tmr_dec       = 1'b1;
          if (tmr_last || tmr_zero) begin
            state_d = ST_MD_RELEASE;
          end
        end
        ST_MD_RELEASE: begin
          // The mul/div still sits in ID/EX this cycle; do not retrigger on it.
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Saturating fetch-stall performance counter.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!fe_enable_o && (stall_cnt_q != STALL_MAX)) begin
      stall_cnt_d = stall_cnt_q + PERF_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign hazard_busy_o = rst_ni && (state_q != ST_IDLE);
  assign stall_cnt_o   = rst_ni ? stall_cnt_q : '0;

endmodule
